// File: rtl/defuzz_pkg.sv
// rtl/defuzz_pkg.sv - shared states, constants and singleton scaling for defuzz_sequencer
package defuzz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    localparam int G_SCALE = 32768;
    localparam int G_MAX   = 100;

    localparam logic [8:0] CORNER_MASK = 9'b101000101;

    // Percent singleton to Q15: clamp to 100 %, then floor(g * 32768 / 100)
    function automatic logic [16:0] g2q15(input logic [7:0] g);
        logic [7:0]  g_clamped;
        logic [23:0] scaled;
        g_clamped = (g > 8'(G_MAX)) ? 8'(G_MAX) : g;
        scaled    = 24'(g_clamped) * 24'(G_SCALE);
        return 17'(scaled / 24'(G_MAX));
    endfunction

endpackage

// File: rtl/serial_div.sv
// rtl/serial_div.sv - restoring divider, one quotient bit per clock, MSB first
module serial_div #(
    parameter int NUM_W  = 27,
    parameter int DEN_W  = 20,
    parameter int Q_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  numerator,
    input  logic [DEN_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [Q_BITS-1:0] quotient
);

    localparam int CNT_W = (Q_BITS > 1) ? $clog2(Q_BITS) : 1;

    logic [DEN_W-1:0]  rem;
    logic [DEN_W-1:0]  den;
    logic [Q_BITS-1:0] num_lo;
    logic [CNT_W-1:0]  cnt;
    logic [DEN_W:0]    trial;
    logic              fits;

    // The quotient is known to fit in Q_BITS, so numerator >> Q_BITS is already below the divisor
    assign trial = {rem, num_lo[Q_BITS-1]};
    assign fits  = (trial >= {1'b0, den});
    assign done  = busy && (cnt == CNT_W'(Q_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            den      <= '0;
            num_lo   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= DEN_W'(numerator >> Q_BITS);
            den      <= divisor;
            num_lo   <= numerator[Q_BITS-1:0];
            cnt      <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            rem      <= fits ? DEN_W'(trial - {1'b0, den}) : DEN_W'(trial);
            num_lo   <= num_lo << 1;
            quotient <= {quotient[Q_BITS-2:0], fits};
            cnt      <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/defuzz_sequencer.sv
// rtl/defuzz_sequencer.sv - Sugeno aggregation/defuzzification sequencer; DEFUZZ_PERF_CNT_EN adds perf counters
module defuzz_sequencer
    import defuzz_pkg::*;
#(
    parameter int N_RULES = 9,
    parameter int ACC_W   = 20,
    parameter int Q_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   reg_mode,
    input  logic [N_RULES*16-1:0]  w_flat,
    input  logic [N_RULES*8-1:0]   g_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_BITS-1:0]      crisp,
    output logic [ACC_W-1:0]       s_w,
    output logic [ACC_W-1:0]       s_wg,
    output logic                   div_zero
`ifdef DEFUZZ_PERF_CNT_EN
    ,
    output logic [31:0]            busy_cycles,
    output logic [15:0]            jobs_done
`endif
);

    localparam int IDX_W = $clog2(N_RULES);
    localparam int NUM_W = ACC_W + 7;

    state_t             state, state_nxt;
    logic [15:0]        w_r [N_RULES];
    logic [7:0]         g_r [N_RULES];
    logic               mode_r;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               is_last;
    logic [N_RULES-1:0] active_mask;
    logic [ACC_W-1:0]   s_w_r, s_wg_r, s_w_nxt, s_wg_nxt;
    logic [16:0]        gq;
    logic [32:0]        prod;
    logic [16:0]        term;
    logic               accept, handshake;
    logic               div_start, div_busy, div_done;
    logic [Q_BITS-1:0]  quotient;
    logic               div_zero_r;

    assign accept    = (state == IDLE) && in_valid;
    assign handshake = (state == DONE) && out_ready;

    assign gq       = g2q15(g_r[idx]);
    assign prod     = 33'(w_r[idx]) * 33'(gq);
    assign term     = 17'(prod >> 15);
    assign s_w_nxt  = s_w_r + ACC_W'(w_r[idx]);
    assign s_wg_nxt = s_wg_r + ACC_W'(term);

    assign active_mask = mode_r ? '1 : N_RULES'(CORNER_MASK);

    // Next active rule above idx; descending scan leaves the smallest one
    always_comb begin
        idx_nxt = idx;
        is_last = 1'b1;
        for (int k = N_RULES - 1; k >= 0; k--) begin
            if ((k > int'(idx)) && active_mask[k]) begin
                idx_nxt = IDX_W'(k);
                is_last = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (is_last) begin
                    if (s_w_nxt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIVIDE;
                        div_start = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (div_done || !div_busy) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_RULES; k++) begin
                w_r[k] <= '0;
                g_r[k] <= '0;
            end
            mode_r     <= 1'b0;
            idx        <= '0;
            s_w_r      <= '0;
            s_wg_r     <= '0;
            div_zero_r <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < N_RULES; k++) begin
                w_r[k] <= w_flat[16*k +: 16];
                g_r[k] <= g_flat[8*k +: 8];
            end
            mode_r     <= reg_mode;
            idx        <= '0;
            s_w_r      <= '0;
            s_wg_r     <= '0;
            div_zero_r <= 1'b0;
        end else if (state == ACCUM) begin
            s_w_r  <= s_w_nxt;
            s_wg_r <= s_wg_nxt;
            idx    <= idx_nxt;
            if (is_last && (s_w_nxt == '0)) begin
                div_zero_r <= 1'b1;
            end
        end
    end

    serial_div #(
        .NUM_W  (NUM_W),
        .DEN_W  (ACC_W),
        .Q_BITS (Q_BITS)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .numerator (NUM_W'(s_wg_nxt) * NUM_W'(100)),
        .divisor   (s_w_nxt),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s_w       = s_w_r;
    assign s_wg      = s_wg_r;
    assign div_zero  = div_zero_r;
    assign crisp     = div_zero_r ? '0 : quotient;

`ifdef DEFUZZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles <= '0;
            jobs_done   <= '0;
        end else begin
            if (state != IDLE) busy_cycles <= busy_cycles + 32'd1;
            if (handshake)     jobs_done   <= jobs_done + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_defuzz_sequencer.sv
// tb/tb_defuzz_sequencer.sv - randomized self-checking bench for defuzz_sequencer against a reference model
module tb_defuzz_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         reg_mode;
    logic [143:0] w_flat;
    logic [71:0]  g_flat;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   crisp;
    logic [19:0]  s_w;
    logic [19:0]  s_wg;
    logic         div_zero;
`ifdef DEFUZZ_PERF_CNT_EN
    logic [31:0]  busy_cycles;
    logic [15:0]  jobs_done;
`endif

    int checks = 0;
    int errors = 0;

    defuzz_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg_mode  (reg_mode),
        .w_flat    (w_flat),
        .g_flat    (g_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crisp     (crisp),
        .s_w       (s_w),
        .s_wg      (s_wg),
        .div_zero  (div_zero)
`ifdef DEFUZZ_PERF_CNT_EN
        ,
        .busy_cycles (busy_cycles),
        .jobs_done   (jobs_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int unsigned w[9], input int unsigned g[9], input bit mode,
                                  output int unsigned sw, output int unsigned swg,
                                  output int unsigned cr, output int unsigned lat);
        int unsigned n = 0;
        longint unsigned gc, gq;
        sw  = 0;
        swg = 0;
        for (int k = 0; k < 9; k++) begin
            if (mode || k == 0 || k == 2 || k == 6 || k == 8) begin
                gc  = (g[k] > 100) ? 100 : g[k];
                gq  = (gc * 32768) / 100;
                sw  += w[k];
                swg += int'((longint'(w[k]) * gq) >> 15);
                n++;
            end
        end
        if (sw == 0) begin
            cr  = 0;
            lat = n;
        end else begin
            cr  = (swg * 100) / sw;
            lat = n + 8;
        end
    endfunction

    task automatic run_job(input int unsigned w[9], input int unsigned g[9], input bit mode,
                           input int stall, output int unsigned ocrisp,
                           output int unsigned olat, output bit odz);
        int unsigned e_sw, e_swg, e_cr, e_lat;
        int lat;
        model(w, g, mode, e_sw, e_swg, e_cr, e_lat);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: got %0b expected 1", in_ready);
        end
        for (int k = 0; k < 9; k++) begin
            w_flat[16*k +: 16] = 16'(w[k]);
            g_flat[8*k +: 8]   = 8'(g[k]);
        end
        reg_mode  = mode;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_ready: got %0b expected 0 at cycle %0d", in_ready, lat);
            end
            in_valid = 1'($urandom);
            reg_mode = 1'($urandom);
            for (int k = 0; k < 9; k++) begin
                w_flat[16*k +: 16] = 16'($urandom);
                g_flat[8*k +: 8]   = 8'($urandom);
            end
            step;
            lat++;
        end
        checks++;
        if (lat != int'(e_lat)) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", lat, e_lat);
        end
        checks++;
        if (crisp !== 8'(e_cr) || s_w !== 20'(e_sw) || s_wg !== 20'(e_swg) || div_zero !== (e_sw == 0)) begin
            errors++;
            $display("FAIL result: got crisp=%0d s_w=%0d s_wg=%0d dz=%0b expected crisp=%0d s_w=%0d s_wg=%0d dz=%0b",
                     crisp, s_w, s_wg, div_zero, e_cr, e_sw, e_swg, e_sw == 0);
        end
        ocrisp = crisp;
        olat   = lat;
        odz    = div_zero;
        for (int s = 0; s < stall; s++) begin
            step;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || crisp !== 8'(e_cr) ||
                s_w !== 20'(e_sw) || s_wg !== 20'(e_swg)) begin
                errors++;
                $display("FAIL stall_hold: got ov=%0b ir=%0b crisp=%0d s_w=%0d expected ov=1 ir=0 crisp=%0d s_w=%0d",
                         out_valid, in_ready, crisp, s_w, e_cr, e_sw);
            end
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: got ov=%0b ir=%0b expected ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reg_mode  = 1'b0;
        w_flat    = '0;
        g_flat    = '0;
        repeat (3) step;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || crisp !== 8'd0 ||
            s_w !== 20'd0 || s_wg !== 20'd0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ir=%0b ov=%0b crisp=%0d s_w=%0d s_wg=%0d dz=%0b expected 1 0 0 0 0 0",
                     in_ready, out_valid, crisp, s_w, s_wg, div_zero);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_mode1_single;
        int unsigned w[9] = '{default: 0};
        int unsigned g[9] = '{default: 0};
        int unsigned cr, lat;
        bit dz;
        w[0] = 32'h8000;
        g[0] = 50;
        run_job(w, g, 1'b1, 0, cr, lat, dz);
        checks++;
        if (cr != 50 || lat != 17 || dz != 1'b0) begin
            errors++;
            $display("FAIL mode1_single: got crisp=%0d lat=%0d dz=%0b expected 50 17 0", cr, lat, dz);
        end
    endtask

    task automatic test_mode0_corner;
        int unsigned w[9] = '{default: 0};
        int unsigned g[9] = '{default: 0};
        int unsigned cr, lat;
        bit dz;
        w[0] = 32'h4000;
        w[4] = 32'h8000;
        g[0] = 20;
        g[4] = 90;
        run_job(w, g, 1'b0, 1, cr, lat, dz);
        checks++;
        if (cr != 19 || lat != 12 || dz != 1'b0) begin
            errors++;
            $display("FAIL mode0_corner: got crisp=%0d lat=%0d dz=%0b expected 19 12 0", cr, lat, dz);
        end
    endtask

    task automatic test_all_zero;
        int unsigned w[9] = '{default: 0};
        int unsigned g[9] = '{default: 77};
        int unsigned cr, lat;
        bit dz;
        run_job(w, g, 1'b0, 2, cr, lat, dz);
        checks++;
        if (cr != 0 || lat != 4 || dz != 1'b1) begin
            errors++;
            $display("FAIL all_zero: got crisp=%0d lat=%0d dz=%0b expected 0 4 1", cr, lat, dz);
        end
    endtask

    task automatic test_clamp_stall;
        int unsigned w[9] = '{default: 0};
        int unsigned g[9] = '{default: 0};
        int unsigned cr, lat;
        bit dz;
        w[0] = 32'h8000;
        g[0] = 200;
        run_job(w, g, 1'b1, 5, cr, lat, dz);
        checks++;
        if (cr != 100 || lat != 17) begin
            errors++;
            $display("FAIL clamp_stall: got crisp=%0d lat=%0d expected 100 17", cr, lat);
        end
    endtask

    task automatic test_abort;
        int unsigned w[9] = '{default: 32'h4000};
        int unsigned g[9] = '{default: 60};
        int unsigned cr, lat;
        bit dz;
        bit seen;
        for (int k = 0; k < 9; k++) begin
            w_flat[16*k +: 16] = 16'h4000;
            g_flat[8*k +: 8]   = 8'd50;
        end
        reg_mode = 1'b1;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (3) step;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s_w !== 20'd0) begin
            errors++;
            $display("FAIL abort_async: got ov=%0b ir=%0b s_w=%0d expected 0 1 0", out_valid, in_ready, s_w);
        end
        step;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (25) begin
            step;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_output: got out_valid=1 expected 0");
        end
        run_job(w, g, 1'b1, 0, cr, lat, dz);
    endtask

    task automatic test_random;
        int unsigned w[9];
        int unsigned g[9];
        int unsigned cr, lat;
        bit dz;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 9; k++) begin
                w[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 32768);
                g[k] = $urandom_range(0, 255);
            end
            if (j == 5) w = '{default: 0};
            run_job(w, g, 1'($urandom), $urandom_range(0, 3), cr, lat, dz);
        end
    endtask

`ifdef DEFUZZ_PERF_CNT_EN
    task automatic test_perf;
        int unsigned w[9] = '{default: 0};
        int unsigned g[9] = '{default: 0};
        int unsigned cr, lat;
        bit dz;
        w[0] = 32'h8000;
        g[0] = 50;
        run_job(w, g, 1'b1, 3, cr, lat, dz);
        run_job(w, g, 1'b1, 3, cr, lat, dz);
        checks++;
        if (jobs_done !== 16'd2 || busy_cycles !== 32'd42) begin
            errors++;
            $display("FAIL perf_counters: got jobs=%0d busy=%0d expected 2 42", jobs_done, busy_cycles);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef DEFUZZ_PERF_CNT_EN
        test_perf;
`endif
        test_mode1_single;
        test_mode0_corner;
        test_all_zero;
        test_clamp_stall;
        test_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
